// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, latency limits and request type for the multi-cycle memory
package mem_pkg;

    localparam int WORD_W              = 16;
    localparam int BYTE_ADDR_W         = 16;
    localparam int DEFAULT_MEM_LATENCY = 4;
    localparam int MAX_MEM_LATENCY     = 8;

    typedef struct packed {
        logic                   enable;
        logic                   wr;
        logic [BYTE_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]      data;
    } mem_req_t;

endpackage

// File: rtl/mem_delay_line.sv
// rtl/mem_delay_line.sv - fixed-latency shift register of {valid, payload}
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid        : push a response this cycle
//   in_payload      : payload pushed with in_valid
//   out_valid       : response leaves the last stage (one-cycle pulse)
//   out_payload     : payload of the last stage; holds when out_valid=0
module mem_delay_line #(
    parameter int LATENCY = 4,
    parameter int W       = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    output logic [W-1:0] out_payload
);

    logic [LATENCY-1:0] valid_q;
    logic [W-1:0]       payload_q [LATENCY];

    // Dropping the valid bits is what discards in-flight reads on reset;
    // the payload is cleared as well only so the outputs start at zero.
    // A stage's payload loads only behind a valid entry, so the last stage
    // (and therefore data_out) holds its value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                payload_q[0] <= in_payload;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    payload_q[i] <= payload_q[i-1];
                end
            end
        end
    end

    assign out_valid   = valid_q[LATENCY-1];
    assign out_payload = payload_q[LATENCY-1];

endmodule

// File: rtl/mem_multicycle.sv
// rtl/mem_multicycle.sv - pipelined word memory with fixed read latency (option: MEM_RANGE_CHECK_EN)
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable, wr  : request valid / 1 = write, 0 = read
//   addr        : byte address, word index = addr[ADDR_WIDTH-1:1]
//   data_in     : write data
//   data_out    : read data, meaningful only while data_valid=1
//   data_valid  : one-cycle pulse per completed read, LATENCY cycles after the request
//   err         : only with MEM_RANGE_CHECK_EN; out-of-range write (next cycle)
//                 or out-of-range read (together with its data_valid)
module mem_multicycle
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = BYTE_ADDR_W,
    parameter int DEPTH      = 32768,
    parameter int LATENCY    = DEFAULT_MEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  oor;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  dl_valid;
    logic [DATA_WIDTH:0]   dl_payload;
    logic [ADDR_WIDTH-1:0] unused_addr;

    // addr[0] selects nothing, and upper word-index bits are dropped when
    // the index wraps modulo DEPTH.
    assign unused_addr = addr;
    assign idx         = addr[IDX_W:1];

`ifdef MEM_RANGE_CHECK_EN
    assign oor = (32'(addr[ADDR_WIDTH-1:1]) >= DEPTH);
`else
    assign oor = 1'b0;
`endif

    assign wr_en = enable & wr & ~oor;
    assign rd_en = enable & ~wr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= data_in;
        end
    end

    // Sampled combinationally and captured by the first delay stage at the
    // accepting edge, so a write on an earlier edge is seen and a later
    // write cannot disturb a read already in flight.
    assign rd_word = oor ? '0 : mem_q[idx];

    mem_delay_line #(
        .LATENCY (LATENCY),
        .W       (DATA_WIDTH + 1)
    ) u_delay_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (rd_en),
        .in_payload  ({oor, rd_word}),
        .out_valid   (dl_valid),
        .out_payload (dl_payload)
    );

    assign data_valid = dl_valid;
    assign data_out   = dl_payload[DATA_WIDTH-1:0];

`ifdef MEM_RANGE_CHECK_EN
    logic wr_err_q;
    logic wr_err_d;

    assign wr_err_d = enable & wr & oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign err = wr_err_q | (dl_valid & dl_payload[DATA_WIDTH]);
`else
    logic unused_err_bit;
    assign unused_err_bit = dl_payload[DATA_WIDTH];
`endif

endmodule
